// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: key codes, FSM state type and
// the key-code to matrix-coordinate lookup.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // row: bit3 = top row; col: bit2 = left column; valid=0 for codes C-F
  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } coord_t;

  function automatic coord_t key_to_coord(input logic [3:0] code);
    coord_t c;
    c = '0;
    c.valid = 1'b1;
    case (code)
      KEY_1:    begin c.row = 4'b1000; c.col = 3'b100; end
      KEY_2:    begin c.row = 4'b1000; c.col = 3'b010; end
      KEY_3:    begin c.row = 4'b1000; c.col = 3'b001; end
      KEY_4:    begin c.row = 4'b0100; c.col = 3'b100; end
      KEY_5:    begin c.row = 4'b0100; c.col = 3'b010; end
      KEY_6:    begin c.row = 4'b0100; c.col = 3'b001; end
      KEY_7:    begin c.row = 4'b0010; c.col = 3'b100; end
      KEY_8:    begin c.row = 4'b0010; c.col = 3'b010; end
      KEY_9:    begin c.row = 4'b0010; c.col = 3'b001; end
      KEY_STAR: begin c.row = 4'b0001; c.col = 3'b100; end
      KEY_0:    begin c.row = 4'b0001; c.col = 3'b010; end
      KEY_HASH: begin c.row = 4'b0001; c.col = 3'b001; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// Small synchronous FIFO for queued key codes. Show-ahead: dout is the head
// entry whenever empty is low. Full/empty come from an occupancy counter, so
// a push and a pop in the same cycle while full leaves the count unchanged.
module keypad_emu_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Storage array; entries need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x3 matrix keypad model. Key codes arrive on a handshake, each is
// pressed for PRESS_CYCLES and then force-released for RELEASE_CYCLES.
// Optional key queue: define KEYPAD_EMU_FIFO_EN to buffer FIFO_DEPTH codes.
//
// Handshake: a code transfers on a rising clk edge where key_valid and
// key_ready are both high; key_valid may be held while key_ready is low and
// key_code must then stay stable until the transfer.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES   = 300,
  parameter int RELEASE_CYCLES = 300,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_code,
  input  logic [3:0] keyboard_rows,
  output logic [2:0] keyboard_cols,
  output logic       busy,
  output logic       done,
  output logic       bad_code,
  output state_e     dbg_state
);

  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_mask_q, row_mask_d;
  logic [2:0]    col_mask_q, col_mask_d;
  logic          bad_q, bad_d;
  logic          done_d;
  logic          code_avail;
  logic [3:0]    code_data;
  coord_t        coord;

`ifdef KEYPAD_EMU_FIFO_EN
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [3:0] fifo_dout;

  // A queued code is taken whenever the FSM is idle; a full queue can still
  // accept in the cycle it pops.
  assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;
  assign key_ready  = ~fifo_full | fifo_pop;
  assign code_avail = fifo_pop;
  assign code_data  = fifo_dout;

  keypad_emu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (key_valid & key_ready),
    .din   (key_code),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  // Direct transfer: the latched masks are the single holding slot, so a new
  // code is only taken while idle.
  assign key_ready  = (state_q == ST_IDLE);
  assign code_avail = key_valid;
  assign code_data  = key_code;
`endif

  assign coord = key_to_coord(code_data);

  // Next-state, counter and mask logic for IDLE -> PRESS -> RELEASE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    bad_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (code_avail) begin
          if (coord.valid) begin
            row_mask_d = coord.row;
            col_mask_d = coord.col;
            cnt_d      = PRESS_LAST;
            state_d    = ST_PRESS;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (cnt_q == '0) begin
          row_mask_d = '0;
          col_mask_d = '0;
          cnt_d      = RELEASE_LAST;
          state_d    = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        row_mask_d = '0;
        col_mask_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State register; reset clears the masks so the switch opens immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      bad_q      <= bad_d;
    end
  end

  // Column return behaves like a closed switch: zero latency from the rows.
  assign keyboard_cols = ((keyboard_rows & row_mask_q) != 4'b0000) ? col_mask_q : 3'b000;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_d;
  assign bad_code      = bad_q;
  assign dbg_state     = state_q;

endmodule
